secuenciador_muestreo: RTL and testbench
========================================

# secuenciador_muestreo

Round-robin sampling scheduler for the temperature-monitoring path. It periodically requests a conversion from a shared ADC for each enabled sensor channel using a req/ack handshake. It then registers each result and emits a one-cycle strobe, together with the channel index and the signed sample. The persistence counters and the per-channel temperature FSMs consume that strobe and sample.

## Interface
Parameters:
- `N_CANALES`, default 4: number of sensor channels, 2..16.
- `PERIODO`, default 1000: cycles from one round start to the next round start, ≥ 4·`N_CANALES`.
- `TIMEOUT`, default 64: maximum cycles `adc_req` stays high without `adc_ack`, ≥ 2.
- `CW`: derived as `$clog2(N_CANALES)`; not overridable.

Ports:
- `clk`  in  1: system clock.
- `arst_n`  in  1: one clock; reset is asynchronous and active-low.
- `habilitar`  in  1: enables sampling rounds.
- `mascara_canal`  in  `N_CANALES`: per-channel enable; bit i = channel i.
- `adc_req`  out  1: conversion request to the shared ADC.
- `adc_canal`  out  `CW`: channel being converted; stable while `adc_req` is high.
- `adc_ack`  in  1: conversion done; qualified only while `adc_req` is high.
- `adc_dato`  in  signed 11: conversion result, valid in the `adc_ack` cycle.
- `temp_registrado`  out  signed 11: last accepted sample.
- `canal_muestra`  out  `CW`: channel of `temp_registrado`.
- `muestra_valida`  out  1: one-cycle strobe, new sample.
- `error_timeout`  out  1: one-cycle strobe, conversion abandoned.
- `canal_error`  out  `CW`: channel that timed out.
- `ronda_fin`  out  1: one-cycle strobe, round complete.
- `sobre_ronda`  out  1: one-cycle strobe, period tick lost because a round was still active.
- `ocupado`  out  1: high in `SOLICITA` and `PAUSA`.

## Operation
- States: `REPOSO`, `ESPERA`, `SOLICITA`, `PAUSA`.
- `REPOSO`:
  - The period counter is held at 0.
  - On `habilitar`=1 with a nonzero mask: select the lowest enabled channel, go to `SOLICITA`, and clear the counter.
- `ESPERA`:
  - The counter runs 0..`PERIODO`-1 and wraps.
  - At the count `PERIODO`-1: start a round (lowest enabled channel) and go to `SOLICITA`.
  - If the mask is zero at that point, stay in `ESPERA`. No `ronda_fin`.
- `SOLICITA`:
  - `adc_req`=1 and `adc_canal`=current channel.
  - On `adc_ack`: latch `adc_dato`→`temp_registrado` and channel→`canal_muestra`, then go to `PAUSA`.
  - On timeout: leave `temp_registrado` unchanged, pulse `error_timeout` with `canal_error`, then go to `PAUSA`.
  - `adc_ack` and timeout in the same cycle: `adc_ack` wins and no error is raised.
- `PAUSA` (exactly 1 cycle, `adc_req`=0):
  - Search for the next enabled channel with a strictly higher index, using the mask value in this cycle.
  - If one is found and `habilitar`=1: go to `SOLICITA`.
  - Otherwise: pulse `ronda_fin`, then go to `ESPERA` if `habilitar`=1, else `REPOSO`.
- The period counter keeps running during a round.
  - If the wrap occurs while in `SOLICITA` or `PAUSA`, pulse `sobre_ronda` and drop that tick; the next round waits for the following wrap.
- `habilitar`=0:
  - In `ESPERA`: go to `REPOSO` next cycle.
  - In `SOLICITA`: the current conversion completes or times out, then the round ends through `PAUSA`.
- `adc_ack` while `adc_req`=0 is ignored.
- `adc_dato` is passed through unmodified (no saturation or scaling).
- Reset values:
  - FSM `REPOSO`.
  - All strobes, `adc_req` and `ocupado` are 0.
  - `adc_canal`, `canal_muestra`, `canal_error` are 0.
  - `temp_registrado` is 0.
  - Counters are 0.
- Reset mid-conversion: `adc_req` drops immediately (asynchronously). No strobe is produced for the interrupted channel.

## Timing
- All outputs are registered.
- Round start: `adc_req` rises in the cycle after the start condition (`habilitar` seen in `REPOSO`, or the wrap cycle in `ESPERA`).
- `adc_ack` sampled high at edge k:
  - `temp_registrado`, `canal_muestra` and `muestra_valida`=1 are valid in cycle k+1.
  - `adc_req` is 0 in cycle k+1.
  - The next channel's `adc_req` is 1 in cycle k+2.
- Timeout: after `adc_req` has been high for `TIMEOUT` cycles with no `adc_ack`, the next cycle has `adc_req`=0 and `error_timeout`=1.
- `ronda_fin` is high in the cycle after the last `PAUSA`.
- Round start to round start is `PERIODO` cycles when no tick is lost.

## Configuration
- `SECUENCIADOR_TIMEOUT_EN` defined:
  - The timeout counter and the `error_timeout`/`canal_error` logic are compiled in, as described above.
- Not defined:
  - `SOLICITA` waits indefinitely for `adc_ack`.
  - `error_timeout` is tied to 0 and `canal_error` to 0.
  - No timeout counter is synthesized.

## Test plan
Bench parameters: `N_CANALES`=4, `PERIODO`=100, `TIMEOUT`=8.
- Mask 4'b1011, `habilitar` 0→1, ADC acks 3 cycles after each `adc_req` with data −40, 200, 300:
  - Requests on channels 0, 1, 3.
  - `muestra_valida` strobes carry (0,−40), (1,200), (3,300).
  - One `ronda_fin`.
  - Next round's `adc_req` rises 100 cycles after the first.
- `adc_ack` never asserted on channel 1:
  - `adc_req` high exactly 8 cycles.
  - `error_timeout`=1 with `canal_error`=1 and `temp_registrado` unchanged.
  - Channel 3 is requested next.
  - Without the macro, `adc_req` stays high indefinitely.
- `adc_ack` arrives in the 8th request cycle on channel 0 (coincides with timeout): sample accepted, no `error_timeout`.
- ADC acks after 40 cycles on every channel with mask 4'b1111: the round exceeds 100 cycles, `sobre_ronda` pulses once, and the next round starts at the following wrap.
- `habilitar` dropped during channel 1's request: channel 1 completes, `ronda_fin` pulses, the FSM goes to `REPOSO`, and channel 3 is never requested.
- `arst_n` asserted while `adc_req`=1: `adc_req`=0 with no clock edge; after release all outputs hold their reset values until `habilitar`.

Source files
------------

// File: rtl/secuenciador_muestreo_if.sv
// ADC conversion handshake between the sampling scheduler (master) and the
// shared ADC (slave).
//
// Handshake: the master raises adc_req with a stable adc_canal and keeps both
// unchanged until it withdraws the request. A conversion completes in a cycle
// where adc_req and adc_ack are both high; adc_dato is meaningful only in that
// cycle. adc_ack seen while adc_req is low carries no meaning and is ignored.
interface secuenciador_muestreo_if #(
  parameter int N_CANALES = 4
);
  localparam int CW = $clog2(N_CANALES);

  logic                 adc_req;
  logic [CW-1:0]        adc_canal;
  logic                 adc_ack;
  logic signed [10:0]   adc_dato;

  modport master (output adc_req, output adc_canal, input adc_ack, input adc_dato);
  modport slave  (input adc_req, input adc_canal, output adc_ack, output adc_dato);
endinterface

// File: rtl/secuenciador_muestreo.sv
// Round-robin sampling scheduler: every PERIODO cycles it walks the enabled
// channels in ascending order, requests one conversion per channel from the
// shared ADC and strobes each result out as a registered sample.
// Optional feature macro: SECUENCIADOR_TIMEOUT_EN compiles in the conversion
// timeout (error_timeout / canal_error); without it a request waits forever.
module secuenciador_muestreo #(
  parameter int N_CANALES = 4,
  parameter int PERIODO   = 1000,
  parameter int TIMEOUT   = 64,
  localparam int CW       = $clog2(N_CANALES)
) (
  input  logic                       clk,
  input  logic                       arst_n,
  input  logic                       habilitar,
  input  logic [N_CANALES-1:0]       mascara_canal,
  secuenciador_muestreo_if.master    adc,
  output logic signed [10:0]         temp_registrado,
  output logic [CW-1:0]              canal_muestra,
  output logic                       muestra_valida,
  output logic                       error_timeout,
  output logic [CW-1:0]              canal_error,
  output logic                       ronda_fin,
  output logic                       sobre_ronda,
  output logic                       ocupado,
  output logic [1:0]                 estado_dbg
);

  localparam int PW = $clog2(PERIODO);

  typedef enum logic [1:0] {REPOSO, ESPERA, SOLICITA, PAUSA} estado_t;

  if (N_CANALES < 2 || N_CANALES > 16 || PERIODO < 4 * N_CANALES || TIMEOUT < 2) begin : g_param_invalido
    $error("secuenciador_muestreo: parameter out of range");
  end

  estado_t            estado, estado_n;
  logic [PW-1:0]      cnt_q, cnt_n;
  logic [CW-1:0]      canal_q, canal_n;
  logic [CW-1:0]      cmuestra_n;
  logic signed [10:0] temp_n;
  logic               mv_n, rf_n, so_n, vuelta;
  logic               req_q, ocupado_q;
  logic [CW:0]        primero, siguiente;

  // Lowest enabled channel with index >= desde; MSB flags that one exists.
  function automatic logic [CW:0] buscar(input logic [N_CANALES-1:0] m, input int desde);
    logic [CW:0] r;
    r = '0;
    for (int i = 0; i < N_CANALES; i++) begin
      if (!r[CW] && i >= desde && m[i]) r = {1'b1, CW'(i)};
    end
    return r;
  endfunction

`ifdef SECUENCIADOR_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT);
  logic [TW-1:0] tcnt_q;
  logic          et_n, et_q;
  logic [CW-1:0] ce_n, ce_q;
  logic          agotado;

  assign agotado = (tcnt_q == TW'(TIMEOUT - 1));

  // Counts request cycles; restarts on every new request.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      tcnt_q <= '0;
      et_q   <= 1'b0;
      ce_q   <= '0;
    end else begin
      tcnt_q <= (estado == SOLICITA && estado_n == SOLICITA) ? tcnt_q + 1'b1 : '0;
      et_q   <= et_n;
      ce_q   <= ce_n;
    end
  end

  assign error_timeout = et_q;
  assign canal_error   = ce_q;
`else
  assign error_timeout = 1'b0;
  assign canal_error   = '0;
`endif

  assign primero   = buscar(mascara_canal, 0);
  assign siguiente = buscar(mascara_canal, int'(canal_q) + 1);
  assign vuelta    = (cnt_q == PW'(PERIODO - 1));

  // Next state, next outputs and period counter.
  always_comb begin
    estado_n   = estado;
    canal_n    = canal_q;
    temp_n     = temp_registrado;
    cmuestra_n = canal_muestra;
    mv_n       = 1'b0;
    rf_n       = 1'b0;
`ifdef SECUENCIADOR_TIMEOUT_EN
    et_n       = 1'b0;
    ce_n       = ce_q;
`endif
    case (estado)
      REPOSO: begin
        if (habilitar && primero[CW]) begin
          estado_n = SOLICITA;
          canal_n  = primero[CW-1:0];
        end
      end
      ESPERA: begin
        if (!habilitar) begin
          estado_n = REPOSO;
        end else if (vuelta && primero[CW]) begin
          estado_n = SOLICITA;
          canal_n  = primero[CW-1:0];
        end
      end
      SOLICITA: begin
        // A completing ack beats a timeout landing in the same cycle.
        if (adc.adc_ack) begin
          temp_n     = adc.adc_dato;
          cmuestra_n = canal_q;
          mv_n       = 1'b1;
          estado_n   = PAUSA;
        end
`ifdef SECUENCIADOR_TIMEOUT_EN
        else if (agotado) begin
          et_n     = 1'b1;
          ce_n     = canal_q;
          estado_n = PAUSA;
        end
`endif
      end
      PAUSA: begin
        if (siguiente[CW] && habilitar) begin
          estado_n = SOLICITA;
          canal_n  = siguiente[CW-1:0];
        end else begin
          rf_n     = 1'b1;
          estado_n = habilitar ? ESPERA : REPOSO;
        end
      end
      default: estado_n = REPOSO;
    endcase

    // The period counter keeps running across rounds; it is only parked in REPOSO.
    if (estado == REPOSO || estado_n == REPOSO) cnt_n = '0;
    else if (vuelta)                            cnt_n = '0;
    else                                        cnt_n = cnt_q + 1'b1;

    so_n = vuelta && (estado == SOLICITA || estado == PAUSA);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      estado          <= REPOSO;
      cnt_q           <= '0;
      canal_q         <= '0;
      temp_registrado <= '0;
      canal_muestra   <= '0;
      muestra_valida  <= 1'b0;
      ronda_fin       <= 1'b0;
      sobre_ronda     <= 1'b0;
      req_q           <= 1'b0;
      ocupado_q       <= 1'b0;
    end else begin
      estado          <= estado_n;
      cnt_q           <= cnt_n;
      canal_q         <= canal_n;
      temp_registrado <= temp_n;
      canal_muestra   <= cmuestra_n;
      muestra_valida  <= mv_n;
      ronda_fin       <= rf_n;
      sobre_ronda     <= so_n;
      req_q           <= (estado_n == SOLICITA);
      ocupado_q       <= (estado_n == SOLICITA || estado_n == PAUSA);
    end
  end

  assign adc.adc_req   = req_q;
  assign adc.adc_canal = canal_q;
  assign ocupado       = ocupado_q;
  assign estado_dbg    = estado;

endmodule

// File: tb/tb_secuenciador_muestreo.sv
// Bench for secuenciador_muestreo: an ADC responder answers each request
// after a planned delay, a monitor logs every observable event with its cycle
// number, and a round-level timeline model predicts the same event list.
module tb_secuenciador_muestreo;
  localparam int N_CANALES = 4;
  localparam int PERIODO   = 100;
  localparam int TIMEOUT   = 8;
  localparam int CW        = 2;
  localparam int W         = 38;
`ifdef SECUENCIADOR_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic arst_n = 1'b0;
  logic habilitar = 1'b0;
  logic [N_CANALES-1:0] mascara_canal = '0;
  logic signed [10:0] temp_registrado;
  logic [CW-1:0] canal_muestra, canal_error;
  logic muestra_valida, error_timeout, ronda_fin, sobre_ronda, ocupado;
  logic [1:0] estado_dbg;

  secuenciador_muestreo_if #(.N_CANALES(N_CANALES)) adc ();

  secuenciador_muestreo #(.N_CANALES(N_CANALES), .PERIODO(PERIODO), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .arst_n(arst_n), .habilitar(habilitar), .mascara_canal(mascara_canal),
    .adc(adc), .temp_registrado(temp_registrado), .canal_muestra(canal_muestra),
    .muestra_valida(muestra_valida), .error_timeout(error_timeout), .canal_error(canal_error),
    .ronda_fin(ronda_fin), .sobre_ronda(sobre_ronda), .ocupado(ocupado), .estado_dbg(estado_dbg)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fallos = 0;

  task automatic chequear(input string tag, input logic [63:0] obs, input logic [63:0] esperado);
    n_checks++;
    if (obs !== esperado) begin
      n_fallos++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, esperado);
    end
  endtask

  // Event word: {cycle, kind, channel, data}. Kinds: 1 req rise, 2 req fall
  // (data = cycles high), 3 sample, 4 timeout, 5 round end, 6 lost tick.
  function automatic logic [W-1:0] ev(input int c, input int tipo, input int canal, input logic [10:0] dato);
    return {c[19:0], tipo[2:0], canal[3:0], dato};
  endfunction

  logic [W-1:0] exp_q[$];
  logic [W-1:0] act_q[$];
  int exp_ocup, act_ocup;
  logic [10:0] mdl_temp = '0;

  // ---------------- ADC responder ----------------
  int resp_dly_q[$], resp_dat_q[$];
  int plan_dly[$], plan_dat[$];
  int req_cnt = 0, cur_dly = 0, cur_dat = 0;

  always @(negedge clk) begin
    if (!arst_n) begin
      adc.adc_ack  = 1'b0;
      adc.adc_dato = '0;
      req_cnt      = 0;
    end else if (adc.adc_req) begin
      if (req_cnt == 0) begin
        cur_dly = 1000;
        cur_dat = 0;
        if (resp_dly_q.size() > 0) begin
          cur_dly = resp_dly_q.pop_front();
          cur_dat = resp_dat_q.pop_front();
        end
      end
      req_cnt++;
      adc.adc_ack  = (req_cnt == cur_dly);
      adc.adc_dato = adc.adc_ack ? 11'(cur_dat) : 11'($urandom);
    end else begin
      // Stray acks while no request is pending must be ignored.
      req_cnt      = 0;
      adc.adc_ack  = ($urandom_range(0, 3) == 0);
      adc.adc_dato = 11'($urandom);
    end
  end

  // ---------------- monitor ----------------
  bit mon_on = 1'b0;
  logic req_prev = 1'b0;
  int rise_cyc = 0;

  always @(negedge clk) begin
    if (arst_n && mon_on) begin
      if (adc.adc_req && !req_prev) begin
        rise_cyc = cyc;
        act_q.push_back(ev(cyc, 1, int'(adc.adc_canal), '0));
      end
      if (!adc.adc_req && req_prev) act_q.push_back(ev(cyc, 2, int'(adc.adc_canal), 11'(cyc - rise_cyc)));
      if (muestra_valida) act_q.push_back(ev(cyc, 3, int'(canal_muestra), temp_registrado));
      if (error_timeout)  act_q.push_back(ev(cyc, 4, int'(canal_error), temp_registrado));
      if (ronda_fin)      act_q.push_back(ev(cyc, 5, 0, '0));
      if (sobre_ronda)    act_q.push_back(ev(cyc, 6, 0, '0));
      if (ocupado)        act_ocup++;
    end
    req_prev = arst_n ? adc.adc_req : 1'b0;
  end

  // ---------------- reference model ----------------
  // A channel answered d cycles after its request occupies d+1 cycles
  // (request + one pause). Rounds start every PERIODO cycles; a round of
  // length L swallows floor(L/PERIODO) ticks.
  task automatic modelar(input logic [3:0] mask, input int n_rondas, input int corte,
                         input int s0, output int t_fin, output int drop_cyc);
    int lst[$];
    int k, s, t, d, dd, largo;
    bit acept;
    for (int i = 0; i < N_CANALES; i++) if (mask[i]) lst.push_back(i);
    k = 0; s = s0; t = s0; drop_cyc = -1; exp_ocup = 0; t_fin = s0;
    for (int r = 0; r < n_rondas; r++) begin
      t = s;
      for (int j = 0; j < lst.size(); j++) begin
        d = plan_dly[k];
        acept = !TO_EN || (d <= TIMEOUT);
        dd = acept ? d : TIMEOUT;
        exp_q.push_back(ev(t, 1, lst[j], '0));
        exp_q.push_back(ev(t + dd, 2, lst[j], 11'(dd)));
        if (acept) begin
          mdl_temp = 11'(plan_dat[k]);
          exp_q.push_back(ev(t + dd, 3, lst[j], mdl_temp));
        end else begin
          exp_q.push_back(ev(t + dd, 4, lst[j], mdl_temp));
        end
        k++;
        if (r == 0 && j == corte) drop_cyc = t + 1;
        t = t + dd + 1;
        if (r == 0 && j == corte) break;
      end
      largo = t - s;
      exp_ocup += largo;
      exp_q.push_back(ev(t, 5, 0, '0));
      for (int w = PERIODO; w <= largo; w += PERIODO) exp_q.push_back(ev(s + w, 6, 0, '0));
      t_fin = t;
      if (corte >= 0) break;
      s = s + PERIODO * (largo / PERIODO + 1);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic plan_push(input int d, input int dat);
    plan_dly.push_back(d);
    plan_dat.push_back(dat);
  endtask

  task automatic escenario(input string nombre, input logic [3:0] mask, input int n_rondas, input int corte);
    int s0, t_fin, drop_cyc;
    logic [W-1:0] a;
    @(negedge clk);
    s0 = cyc + 1;
    resp_dly_q = plan_dly;
    resp_dat_q = plan_dat;
    exp_q.delete();
    act_q.delete();
    act_ocup = 0;
    modelar(mask, n_rondas, corte, s0, t_fin, drop_cyc);
    mascara_canal = mask;
    habilitar = 1'b1;
    mon_on = 1'b1;
    while (cyc < t_fin + 6) begin
      @(negedge clk);
      if (cyc == drop_cyc || (drop_cyc < 0 && cyc == t_fin)) habilitar = 1'b0;
    end
    mon_on = 1'b0;
    act_q.sort();
    exp_q.sort();
    chequear({nombre, "_n_eventos"}, act_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      a = (i < act_q.size()) ? act_q[i] : '1;
      chequear($sformatf("%s_ev%0d", nombre, i), a, exp_q[i]);
    end
    chequear({nombre, "_ciclos_ocupado"}, act_ocup, exp_ocup);
    chequear({nombre, "_fin_reposo"}, {adc.adc_req, ocupado, estado_dbg}, '0);
  endtask

  task automatic escenario_aleatorio(input int idx);
    logic [3:0] m;
    int n_r, corte, d;
    m = 4'($urandom_range(1, 15));
    n_r = $urandom_range(1, 2);
    corte = -1;
    if ($urandom_range(0, 2) == 0) begin
      n_r = 1;
      corte = $urandom_range(0, $countones(m) - 1);
    end
    plan_dly.delete();
    plan_dat.delete();
    for (int i = 0; i < n_r * $countones(m); i++) begin
      d = ($urandom_range(0, 3) == 0) ? $urandom_range(30, 45) : $urandom_range(1, 12);
      if (i == corte && d < 2) d = 2;
      plan_push(d, $urandom_range(0, 2047) - 1024);
    end
    escenario($sformatf("rnd%0d", idx), m, n_r, corte);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #5ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fallos + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int espera;
    arst_n = 1'b0;
    repeat (3) @(negedge clk);
    chequear("rst_adc_req", adc.adc_req, '0);
    chequear("rst_strobes", {muestra_valida, error_timeout, ronda_fin, sobre_ronda, ocupado}, '0);
    chequear("rst_canales", {adc.adc_canal, canal_muestra, canal_error}, '0);
    chequear("rst_temp", temp_registrado, '0);
    chequear("rst_estado", estado_dbg, '0);
    arst_n = 1'b1;
    repeat (3) @(negedge clk);
    chequear("idle_sin_habilitar", {adc.adc_req, ocupado, ronda_fin, estado_dbg}, '0);

    // Mask 1011, two rounds, ack three cycles into each request.
    plan_dly.delete(); plan_dat.delete();
    plan_push(3, -40); plan_push(3, 200); plan_push(3, 300);
    for (int i = 0; i < 3; i++) plan_push(3, $urandom_range(0, 2047) - 1024);
    escenario("basico", 4'b1011, 2, -1);

    // Channel 1 never answers within the timeout window.
    plan_dly.delete(); plan_dat.delete();
    plan_push(2, 11); plan_push(30, 22); plan_push(4, 33);
    escenario("timeout", 4'b1011, 1, -1);

    // Ack lands in the last request cycle before the timeout.
    plan_dly.delete(); plan_dat.delete();
    plan_push(TIMEOUT, 77);
    escenario("coincide", 4'b0001, 1, -1);
    plan_dly.delete(); plan_dat.delete();
    plan_push(TIMEOUT + 1, 88);
    escenario("pasado", 4'b0001, 1, -1);

    // Slow ADC: round overruns the period, then a normal round.
    plan_dly.delete(); plan_dat.delete();
    for (int i = 0; i < 4; i++) plan_push(40, 100 + i);
    for (int i = 0; i < 4; i++) plan_push(3, -500 + i);
    escenario("sobre", 4'b1111, 2, -1);

    // Enable dropped during channel 1's request.
    plan_dly.delete(); plan_dat.delete();
    plan_push(3, 5); plan_push(5, -6); plan_push(3, 7);
    escenario("corte", 4'b1011, 1, 1);

    // Reset in the middle of a conversion.
    plan_dly.delete(); plan_dat.delete();
    resp_dly_q = {50};
    resp_dat_q = {9};
    @(negedge clk);
    mascara_canal = 4'b0001;
    habilitar = 1'b1;
    espera = 0;
    while (!adc.adc_req && espera < 10) begin
      @(negedge clk);
      espera++;
    end
    chequear("rst_mid_req_alto", adc.adc_req, 1);
    repeat (3) @(negedge clk);
    #2 arst_n = 1'b0;
    #1 chequear("rst_mid_req_async", {adc.adc_req, ocupado}, '0);
    habilitar = 1'b0;
    @(negedge clk);
    arst_n = 1'b1;
    mdl_temp = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chequear($sformatf("post_rst_salidas%0d", i),
               {adc.adc_req, ocupado, muestra_valida, error_timeout, ronda_fin, sobre_ronda,
                temp_registrado, canal_muestra, canal_error, adc.adc_canal, estado_dbg}, '0);
    end

    for (int i = 0; i < 6; i++) escenario_aleatorio(i);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fallos);
    $finish;
  end
endmodule
